// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM lane demultiplexer.
package tdm_pkg;

  localparam int unsigned TDM_WIDTH = 8;
  localparam int unsigned TDM_LANES = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } tdm_state_e;

endpackage

// File: rtl/demux_lane_decode.sv
// Turns a slot index plus enable into a one-hot lane write enable.
module demux_lane_decode
  import tdm_pkg::*;
#(
  parameter int unsigned LANES = TDM_LANES,
  parameter int unsigned SW    = $clog2(LANES) + 1
) (
  input  logic [SW-1:0]    slot_i,
  input  logic             en_i,
  output logic [LANES-1:0] we_o
);

  always_comb begin
    we_o = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (en_i && (slot_i == SW'(k))) we_o[k] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Collects LANES time-multiplexed beats into one parallel frame and holds it
// until the consumer takes it; protocol errors pulse frame_err and are counted.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = TDM_WIDTH,
  parameter int unsigned LANES = TDM_LANES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  input  logic                   in_sof,
  output logic                   in_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_err,
  output logic [7:0]             err_cnt
);

  localparam int unsigned SW = $clog2(LANES) + 1;

  tdm_state_e                   state_q, state_d;
  logic       [SW-1:0]          slot_q, slot_d;
  logic       [LANES-1:0][WIDTH-1:0] lane_q;
  logic                         err_q, err_d;
  logic       [7:0]             err_cnt_q;

  logic                         accept;
  logic                         wr_en;
  logic       [SW-1:0]          wr_slot;
  logic       [LANES-1:0]       we;

  // All outputs come from registers only; nothing from in_* reaches out_*.
  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign out_data  = lane_q;
  assign frame_err = err_q;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_slot = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_sof) begin
            wr_en   = 1'b1;
            slot_d  = SW'(1);
            state_d = (LANES == 1) ? HOLD : COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          wr_en = 1'b1;
          if (in_sof) begin
            // Restart: the partial frame is abandoned, this beat becomes lane 0.
            err_d  = 1'b1;
            slot_d = SW'(1);
          end else begin
            wr_slot = slot_q;
            slot_d  = slot_q + 1'b1;
            if (slot_q == SW'(LANES - 1)) begin
              state_d = HOLD;
              slot_d  = '0;
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          slot_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      err_q   <= err_d;
      if (err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (we[k]) lane_q[k] <= in_data;
      end
    end
  end

  demux_lane_decode #(
    .LANES (LANES),
    .SW    (SW)
  ) u_decode (
    .slot_i (wr_slot),
    .en_i   (wr_en),
    .we_o   (we)
  );

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: frames go through a scoreboard queue popped by
// a monitor on each output handshake; control/error outputs are checked inline.
module tb_tdm_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid, in_sof, in_ready;
  logic [31:0] out_data;
  logic        out_valid, out_ready, frame_err;
  logic [7:0]  err_cnt;

  logic [7:0]  s_in_data;
  logic        s_in_valid, s_in_sof, s_in_ready;
  logic [7:0]  s_out_data;
  logic        s_out_valid, s_out_ready, s_frame_err;
  logic [7:0]  s_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  s_exp_q[$];

  tdm_demux #(.WIDTH(8), .LANES(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err),
    .err_cnt(err_cnt)
  );

  tdm_demux #(.WIDTH(8), .LANES(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(s_in_data), .in_valid(s_in_valid),
    .in_sof(s_in_sof), .in_ready(s_in_ready), .out_data(s_out_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .frame_err(s_frame_err),
    .err_cnt(s_err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic sof);
    in_data  = d;
    in_sof   = sof;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Monitor: pops expected frames on handshake and checks HOLD stability.
  logic        held = 1'b0;
  logic [31:0] held_data = '0;
  always @(negedge clk) begin
    if (held) begin
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_data", out_data, held_data);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_frame: got 0x%0h, expected none", out_data);
      end else begin
        chk("frame_data", out_data, exp_q.pop_front());
      end
    end
    if (s_out_valid && s_out_ready) begin
      if (s_exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_frame_l1: got 0x%0h, expected none", s_out_data);
      end else begin
        chk("frame_data_l1", {24'b0, s_out_data}, {24'b0, s_exp_q.pop_front()});
      end
    end
    held      = out_valid && !out_ready && !reset;
    held_data = out_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_data = '0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    s_in_data = '0; s_in_valid = 1'b0; s_in_sof = 1'b0; s_out_ready = 1'b1;
    tick(2);
    reset = 1'b0;

    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
    chk("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic frame, consumer always ready.
    exp_q.push_back(32'hD3C2B1A0);
    beat(8'hA0, 1'b1);
    beat(8'hB1, 1'b0);
    beat(8'hC2, 1'b0);
    beat(8'hD3, 1'b0);
    chk("t1_out_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_in_ready", {31'b0, in_ready}, 32'd0);
    chk("t1_frame_err", {31'b0, frame_err}, 32'd0);
    tick(1);
    chk("t1_released", {31'b0, out_valid}, 32'd0);

    // Backpressure: frame held while a sof beat waits.
    out_ready = 1'b0;
    exp_q.push_back(32'h40302010);
    beat(8'h10, 1'b1);
    beat(8'h20, 1'b0);
    beat(8'h30, 1'b0);
    beat(8'h40, 1'b0);
    in_data = 8'h11; in_sof = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_in_ready", {31'b0, in_ready}, 32'd0);
      chk("t2_out_data", out_data, 32'h40302010);
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    chk("t2_idle_valid", {31'b0, out_valid}, 32'd0);
    chk("t2_idle_ready", {31'b0, in_ready}, 32'd1);
    exp_q.push_back(32'h14131211);
    tick(1);
    in_valid = 1'b0; in_sof = 1'b0;
    beat(8'h12, 1'b0);
    beat(8'h13, 1'b0);
    beat(8'h14, 1'b0);
    tick(1);

    // Stray beat in IDLE, then a restart in the middle of a frame.
    beat(8'h55, 1'b0);
    chk("t3_err_pulse", {31'b0, frame_err}, 32'd1);
    chk("t3_err_cnt1", {24'b0, err_cnt}, 32'd1);
    chk("t3_no_write", out_data, 32'h14131211);
    exp_q.push_back(32'h06050403);
    beat(8'h01, 1'b1);
    chk("t3_err_one_cycle", {31'b0, frame_err}, 32'd0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b1);
    chk("t3_restart_err", {31'b0, frame_err}, 32'd1);
    chk("t3_err_cnt2", {24'b0, err_cnt}, 32'd2);
    beat(8'h04, 1'b0);
    beat(8'h05, 1'b0);
    beat(8'h06, 1'b0);
    chk("t3_out_valid", {31'b0, out_valid}, 32'd1);
    tick(1);

    // Reset mid-frame with a competing beat on the same cycle.
    beat(8'hAA, 1'b1);
    beat(8'hBB, 1'b0);
    in_data = 8'hEE; in_sof = 1'b0; in_valid = 1'b1; reset = 1'b1;
    tick(1);
    reset = 1'b0; in_valid = 1'b0;
    chk("t4_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t4_rst_data", out_data, 32'h0);
    chk("t4_rst_err", {31'b0, frame_err}, 32'd0);
    chk("t4_rst_cnt", {24'b0, err_cnt}, 32'd0);
    chk("t4_rst_ready", {31'b0, in_ready}, 32'd1);
    beat(8'hCC, 1'b0);
    beat(8'hDD, 1'b0);
    tick(2);
    chk("t4_err_cnt", {24'b0, err_cnt}, 32'd2);
    chk("t4_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t4_out_data", out_data, 32'h0);

    // Saturation of the error counter.
    in_sof = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      in_data = k[7:0];
      tick(1);
      if (k == 1) chk("t5_err_pulse", {31'b0, frame_err}, 32'd1);
      if (k >= 252 && k <= 254) begin
        int e;
        e = (2 + k > 255) ? 255 : 2 + k;
        chk("t5_err_sat_edge", {24'b0, err_cnt}, e);
      end
    end
    in_valid = 1'b0;
    tick(1);
    chk("t5_err_cnt", {24'b0, err_cnt}, 32'd255);
    chk("t5_err_idle", {31'b0, frame_err}, 32'd0);
    chk("t5_out_data", out_data, 32'h0);
    chk("t5_out_valid", {31'b0, out_valid}, 32'd0);

    // Single-lane instance: every sof beat is a complete frame.
    chk("l1_in_ready", {31'b0, s_in_ready}, 32'd1);
    s_exp_q.push_back(8'h7E);
    s_in_data = 8'h7E; s_in_sof = 1'b1; s_in_valid = 1'b1;
    tick(1);
    s_in_valid = 1'b0; s_in_sof = 1'b0;
    chk("l1_out_valid", {31'b0, s_out_valid}, 32'd1);
    chk("l1_out_data", {24'b0, s_out_data}, 32'h7E);
    chk("l1_frame_err", {31'b0, s_frame_err}, 32'd0);
    tick(1);
    chk("l1_released", {31'b0, s_out_valid}, 32'd0);

    tick(2);
    chk("sb_empty", exp_q.size(), 32'd0);
    chk("sb_empty_l1", s_exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Parameters
REQ-001 SHALL have parameter WIDTH, default 8: bits per lane/beat.
REQ-002 SHALL have parameter LANES, default 4: lanes per frame, legal range 1..16.

Interface
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
REQ-005 SHALL have port in_data  input  WIDTH  time-multiplexed beat.
REQ-006 SHALL have port in_valid  input  1  in_data valid this cycle.
REQ-007 SHALL have port in_sof  input  1  beat is slot 0 of a frame; qualified by in_valid.
REQ-008 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-009 SHALL have port out_data  output  LANES*WIDTH  assembled frame; lane k at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid  output  1  out_data holds a complete frame.
REQ-011 SHALL have port out_ready  input  1  frame consumed when out_valid && out_ready.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a protocol error.
REQ-013 SHALL have port err_cnt  output  8  saturating count of frame_err pulses.

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT, HOLD, with a slot counter of width $clog2(LANES)+1.
REQ-015 SHALL drive in_ready=1 in IDLE and COLLECT and in_ready=0 in HOLD.
REQ-016 IDLE: an accepted beat with in_sof SHALL write lane 0 and set slot=1; the FSM SHALL go to COLLECT, or to HOLD if LANES==1.
REQ-017 IDLE: an accepted beat without in_sof SHALL be dropped, SHALL pulse frame_err next cycle, and the FSM SHALL stay in IDLE.
REQ-018 COLLECT: an accepted beat without in_sof SHALL write lane[slot] and increment slot.
REQ-019 COLLECT: the beat written at slot==LANES-1 SHALL move the FSM to HOLD, with out_valid=1 the following cycle (latency 1 from the last beat).
REQ-020 COLLECT: an accepted beat with in_sof SHALL pulse frame_err, discard the partial frame, write lane 0, and set slot=1 (restart).
REQ-021 COLLECT: cycles with in_valid=0 SHALL hold all state; no timeout.
REQ-022 HOLD: out_data and out_valid SHALL be stable until out_valid && out_ready.
REQ-023 On out_valid && out_ready, out_valid SHALL be 0 next cycle and the FSM SHALL return to IDLE; lanes SHALL retain old data until overwritten.
REQ-024 out_data SHALL be driven straight from the lane registers, with no combinational path from in_* to out_*.
REQ-025 err_cnt SHALL increment on each frame_err pulse and saturate at 255, with no wrap.
REQ-026 frame_err SHALL be registered and high for exactly one cycle per error event.

Reset
REQ-027 reset SHALL force: state=IDLE, slot=0, out_valid=0, out_data=0, frame_err=0, err_cnt=0.
REQ-028 reset SHALL take priority over every other event in the same cycle.
REQ-029 reset mid-frame or in HOLD SHALL discard the frame, with no out_valid and no frame_err.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-031 Package tdm_pkg SHALL hold the state enum (IDLE, COLLECT, HOLD) and the default WIDTH/LANES constants.
REQ-032 Slot-to-lane write enable SHALL be a sub-module demux_lane_decode (slot, en -> one-hot LANES-bit write enable).
REQ-033 The design SHALL contain no latches and no multi-driven nets.

Verification (WIDTH=8, LANES=4)
REQ-034 Beats A0(sof),B1,C2,D3 with out_ready=1 -> out_valid one cycle after D3, out_data=0xD3C2B1A0, frame_err=0.
REQ-035 Full frame with out_ready=0 for 5 cycles, then a sof beat 0x11 presented -> out_valid held, out_data stable, in_ready=0, beat not taken; after out_ready pulse -> IDLE, 0x11(sof) accepted.
REQ-036 Beats 0x55(no sof) in IDLE -> frame_err pulse, err_cnt=1, no write; then 0x01(sof),0x02,0x03(sof),0x04,0x05,0x06 -> frame_err at 0x03, out_data=0x06050403.
REQ-037 0xAA(sof),0xBB, then reset for 1 cycle, then 0xCC,0xDD (no sof) -> out_valid never set, err_cnt=2 (counted after reset), out_data=0.
REQ-038 300 non-sof beats in IDLE -> err_cnt saturates at 255.
REQ-039 LANES=1 instance: beat 0x7E(sof) -> out_valid next cycle, out_data=0x7E.
